// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_9_bit.sv
// Combinational 9-bit ripple-borrow subtractor built from one-bit full-subtractor slices.
module full_sub_9_bit (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow_out
);

  logic [9:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < 9; i++) begin : g_slice
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow_out = bw[9];

endmodule

// File: rtl/div_8_bit_seq.sv
// Sequential 8-bit unsigned restoring divider, one subtract-and-restore step per cycle.
// Define DIV_BY_ZERO_CHK_EN to short-circuit a zero divisor straight to DONE with err set.
module div_8_bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err
);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_step;
  logic             unused_bits;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign shifted = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};

  full_sub_9_bit u_sub (
    .a          (shifted),
    .b          ({1'b0, dvsr}),
    .diff       (diff),
    .borrow_out (borrow)
  );

  assign r_next    = borrow ? shifted : diff;
  assign q_next    = {quo_r[WIDTH-2:0], ~borrow};
  assign last_step = (cnt == CNT_LAST);

  // The top remainder bit is always zero after a step; kept for the 9-bit algorithm width.
  assign unused_bits = ^{rem_r[WIDTH], diff[WIDTH]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef DIV_BY_ZERO_CHK_EN
  logic div_zero;
  logic err_r;
  assign div_zero = (divisor == '0);
  assign err      = err_r;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_BY_ZERO_CHK_EN
          next_state = div_zero ? DONE : RUN;
`else
          next_state = RUN;
`endif
        end
      end
      RUN: begin
        if (last_step) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_BY_ZERO_CHK_EN
      err_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvsr  <= divisor;
            rem_r <= '0;
            quo_r <= dividend;
            cnt   <= '0;
`ifdef DIV_BY_ZERO_CHK_EN
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dividend;
              err_r     <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          rem_r <= r_next;
          quo_r <= q_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
`ifdef DIV_BY_ZERO_CHK_EN
            err_r     <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_8_bit_seq.sv
// Scoreboard bench for div_8_bit_seq: directed divisions, reset behaviour and handshake timing.
module tb_div_8_bit_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       err;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;

  div_8_bit_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_BY_ZERO_CHK_EN
  localparam logic ZERO_ERR = 1'b1;
  localparam int   ZERO_LAT = 0;
`else
  localparam logic ZERO_ERR = 1'b0;
  localparam int   ZERO_LAT = 8;
`endif

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one request; releasing reset on the same negedge makes the next edge the accepting one.
  task automatic issue(input logic [7:0] dd, input logic [7:0] dv, input logic [7:0] eq,
                       input logic [7:0] er, input logic ee, input int lat, input logic hold);
    exp_t e;
    @(negedge clk);
    reset    = 1'b0;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.e = ee; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
    if (!hold) start = 1'b0;
    check("busy_after_accept", int'(busy), (lat != 0) ? 1 : 0);
  endtask

  task automatic wait_done(input int bound);
    int seen;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) check("done_timeout", 0, 1);
  endtask

  task automatic monitor_step();
    exp_t e;
    if (!reset && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("err", int'(err), int'(e.e));
        check("latency", cyc - e.acc, e.lat);
        check("busy_at_done", int'(busy), 0);
      end
    end
  endtask

  initial begin
    int dc0;
    exp_t dropped;
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_err", int'(err), 0);

    // Start on the first edge after reset release.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, 1'b0);
    wait_done(12);

    // Back-to-back at minimum spacing; results must hold while the next one runs.
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, 1'b0);
    wait_done(12);
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("hold_quotient", int'(quotient), 255);
    check("hold_remainder", int'(remainder), 0);
    wait_done(12);

    // Divide by zero.
    issue(8'd37, 8'd0, 8'hFF, 8'd37, ZERO_ERR, ZERO_LAT, 1'b0);
    wait_done(12);

    // Start held high through RUN and DONE gives one operation only.
    dc0 = done_cnt;
    issue(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 8, 1'b1);
    wait_done(12);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("single_done_pulse", done_cnt - dc0, 1);

    // Reset in the middle of RUN aborts without a done pulse.
    dc0 = done_cnt;
    issue(8'd99, 8'd4, 8'd24, 8'd3, 1'b0, 8, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    dropped = sb.pop_back();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_err", int'(err), 0);
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    issue(8'd99, 8'd4, 8'd24, 8'd3, 1'b0, 8, 1'b0);
    wait_done(12);

    issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8, 1'b0);
    wait_done(12);
    issue(8'd7, 8'd200, 8'd0, 8'd7, 1'b0, 8, 1'b0);
    wait_done(12);
    issue(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 8, 1'b0);
    wait_done(12);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
